// File: rtl/vid_timing_gen.sv
// -----------------------------------------------------------------------------
// vid_timing_gen
//
// Video raster timing and test-pattern generator feeding the TMDS encoder.
// Produces sync, data-enable, pixel coordinates, a frame strobe and RGB data
// for a raster geometry fixed by parameters. The raster runs while en=1 and
// parks at the origin with idle outputs while en=0.
//
// Ports
//   sclk          in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   en            in   run enable; low holds the raster idle at (0,0)
//   pat_sel       in   pattern: 0 colour bars, 1 ramp, 2 grid, 3 solid
//   solid_rgb     in   {r,g,b} colour used by the solid pattern
//   hs / vs       out  horizontal / vertical sync (asserted level HS_POL/VS_POL)
//   video_active  out  data enable
//   rdata/gdata/bdata out pixel data, zero outside the active region
//   x / y         out  coordinates of the pixel currently on the outputs
//   frame_start   out  one-cycle pulse accompanying pixel (0,0)
//
// Every output is registered and reflects the counter state of the previous
// cycle, so all outputs share the same one-cycle latency.
// -----------------------------------------------------------------------------
module vid_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   DATA_W   = 8,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  CW       = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            pat_sel,
    input  logic [3*DATA_W-1:0]   solid_rgb,
    output logic                  hs,
    output logic                  vs,
    output logic                  video_active,
    output logic [DATA_W-1:0]     rdata,
    output logic [DATA_W-1:0]     gdata,
    output logic [DATA_W-1:0]     bdata,
    output logic [CW-1:0]         x,
    output logic [CW-1:0]         y,
    output logic                  frame_start
);

    // Zero-size sync or active regions make no sense as a raster.
    generate
        if (H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0) begin : g_bad_geometry
            $error("vid_timing_gen: H_SYNC, H_ACTIVE, V_SYNC and V_ACTIVE must be non-zero");
        end
    endgenerate

    // Comparisons are done on a widened copy of the counters so that region
    // boundaries equal to H_TOTAL/V_TOTAL never overflow the counter width,
    // and so the grid pattern can always look at the low four bits.
    localparam int EW = CW + 4;

    localparam logic [CW-1:0] ZERO_CW = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

    localparam logic [EW-1:0] H_ACT_E  = EW'(H_ACTIVE);
    localparam logic [EW-1:0] HS_BEG_E = EW'(H_ACTIVE + H_FP);
    localparam logic [EW-1:0] HS_END_E = EW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EW-1:0] V_ACT_E  = EW'(V_ACTIVE);
    localparam logic [EW-1:0] VS_BEG_E = EW'(V_ACTIVE + V_FP);
    localparam logic [EW-1:0] VS_END_E = EW'(V_ACTIVE + V_FP + V_SYNC);

    // A bar narrower than one pixel means every active pixel is remainder,
    // which belongs to the last (black) bar.
    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam int            BAR_W_C  = (BAR_W < 1) ? 1 : BAR_W;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W_C - 1);
    localparam logic [2:0]    BAR_IDX0 = (BAR_W < 1) ? 3'd7 : 3'd0;

    // Channel on/off mask {r,g,b} for each colour bar.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111; // white
            3'd1:    m = 3'b110; // yellow
            3'd2:    m = 3'b011; // cyan
            3'd3:    m = 3'b010; // green
            3'd4:    m = 3'b101; // magenta
            3'd5:    m = 3'b100; // red
            3'd6:    m = 3'b001; // blue
            default: m = 3'b000; // black
        endcase
        return m;
    endfunction

    logic [CW-1:0]         h_cnt_r;
    logic [CW-1:0]         v_cnt_r;
    logic [CW-1:0]         bar_pos_r;
    logic [2:0]            bar_idx_r;
    logic [1:0]            pat_r;
    logic [3*DATA_W-1:0]   solid_r;

    logic [EW-1:0]         h_ext_s;
    logic [EW-1:0]         v_ext_s;
    logic                  origin_s;
    logic                  active_s;
    logic                  hs_s;
    logic                  vs_s;
    logic [1:0]            pat_eff_s;
    logic [3*DATA_W-1:0]   solid_eff_s;
    logic [2:0]            bar_mask_s;
    logic [DATA_W-1:0]     ramp_s;
    logic [DATA_W-1:0]     r_s;
    logic [DATA_W-1:0]     g_s;
    logic [DATA_W-1:0]     b_s;

    logic                  hs_r;
    logic                  vs_r;
    logic                  active_r;
    logic [DATA_W-1:0]     rdata_r;
    logic [DATA_W-1:0]     gdata_r;
    logic [DATA_W-1:0]     bdata_r;
    logic [CW-1:0]         x_r;
    logic [CW-1:0]         y_r;
    logic                  frame_start_r;

    assign h_ext_s  = {4'b0000, h_cnt_r};
    assign v_ext_s  = {4'b0000, v_cnt_r};
    assign origin_s = (h_cnt_r == ZERO_CW) && (v_cnt_r == ZERO_CW);
    assign ramp_s   = DATA_W'(h_cnt_r);

    // Raster counters: advance while enabled, park at the origin otherwise.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= ZERO_CW;
            v_cnt_r <= ZERO_CW;
        end else if (!en) begin
            h_cnt_r <= ZERO_CW;
            v_cnt_r <= ZERO_CW;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= ZERO_CW;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= ZERO_CW;
            end else begin
                v_cnt_r <= v_cnt_r + ONE_CW;
            end
        end else begin
            h_cnt_r <= h_cnt_r + ONE_CW;
        end
    end

    // Bar index tracks h_cnt / BAR_W incrementally, saturating at bar 7 so
    // remainder pixels and blanking stay on the last bar.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pos_r <= ZERO_CW;
            bar_idx_r <= BAR_IDX0;
        end else if (!en || (h_cnt_r == H_LAST)) begin
            bar_pos_r <= ZERO_CW;
            bar_idx_r <= BAR_IDX0;
        end else if (bar_pos_r == BAR_LAST) begin
            bar_pos_r <= ZERO_CW;
            if (bar_idx_r != 3'd7) begin
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_idx_r <= bar_idx_r;
            end
        end else begin
            bar_pos_r <= bar_pos_r + ONE_CW;
        end
    end

    // Pattern controls are latched only at the frame origin so a frame never tears.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r   <= 2'd0;
            solid_r <= {(3*DATA_W){1'b0}};
        end else if (en && origin_s) begin
            pat_r   <= pat_sel;
            solid_r <= solid_rgb;
        end else begin
            pat_r   <= pat_r;
            solid_r <= solid_r;
        end
    end

    // Region decode for the current counter position.
    always_comb begin
        active_s = (h_ext_s < H_ACT_E) && (v_ext_s < V_ACT_E);
        if ((h_ext_s >= HS_BEG_E) && (h_ext_s < HS_END_E)) begin
            hs_s = HS_POL;
        end else begin
            hs_s = ~HS_POL;
        end
        if ((v_ext_s >= VS_BEG_E) && (v_ext_s < VS_END_E)) begin
            vs_s = VS_POL;
        end else begin
            vs_s = ~VS_POL;
        end
    end

    // Pixel generation. At the origin the shadow registers load on this same
    // edge, so pixel (0,0) uses the live controls to match the new frame.
    always_comb begin
        pat_eff_s   = pat_r;
        solid_eff_s = solid_r;
        if (origin_s) begin
            pat_eff_s   = pat_sel;
            solid_eff_s = solid_rgb;
        end else begin
            pat_eff_s   = pat_r;
            solid_eff_s = solid_r;
        end
        bar_mask_s = bar_mask(bar_idx_r);
        r_s = {DATA_W{1'b0}};
        g_s = {DATA_W{1'b0}};
        b_s = {DATA_W{1'b0}};
        if (active_s) begin
            case (pat_eff_s)
                2'd0: begin
                    r_s = {DATA_W{bar_mask_s[2]}};
                    g_s = {DATA_W{bar_mask_s[1]}};
                    b_s = {DATA_W{bar_mask_s[0]}};
                end
                2'd1: begin
                    r_s = ramp_s;
                    g_s = ramp_s;
                    b_s = ramp_s;
                end
                2'd2: begin
                    if ((h_ext_s[3:0] == 4'd0) || (v_ext_s[3:0] == 4'd0)) begin
                        r_s = {DATA_W{1'b1}};
                        g_s = {DATA_W{1'b1}};
                        b_s = {DATA_W{1'b1}};
                    end else begin
                        r_s = {DATA_W{1'b0}};
                        g_s = {DATA_W{1'b0}};
                        b_s = {DATA_W{1'b0}};
                    end
                end
                2'd3: begin
                    r_s = solid_eff_s[3*DATA_W-1 -: DATA_W];
                    g_s = solid_eff_s[2*DATA_W-1 -: DATA_W];
                    b_s = solid_eff_s[DATA_W-1:0];
                end
                default: begin
                    r_s = {DATA_W{1'b0}};
                    g_s = {DATA_W{1'b0}};
                    b_s = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            r_s = {DATA_W{1'b0}};
            g_s = {DATA_W{1'b0}};
            b_s = {DATA_W{1'b0}};
        end
    end

    // Output register stage; idle levels under reset and while disabled.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r          <= ~HS_POL;
            vs_r          <= ~VS_POL;
            active_r      <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
            gdata_r       <= {DATA_W{1'b0}};
            bdata_r       <= {DATA_W{1'b0}};
            x_r           <= ZERO_CW;
            y_r           <= ZERO_CW;
            frame_start_r <= 1'b0;
        end else if (!en) begin
            hs_r          <= ~HS_POL;
            vs_r          <= ~VS_POL;
            active_r      <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
            gdata_r       <= {DATA_W{1'b0}};
            bdata_r       <= {DATA_W{1'b0}};
            x_r           <= ZERO_CW;
            y_r           <= ZERO_CW;
            frame_start_r <= 1'b0;
        end else begin
            hs_r          <= hs_s;
            vs_r          <= vs_s;
            active_r      <= active_s;
            rdata_r       <= r_s;
            gdata_r       <= g_s;
            bdata_r       <= b_s;
            x_r           <= h_cnt_r;
            y_r           <= v_cnt_r;
            frame_start_r <= origin_s;
        end
    end

    assign hs           = hs_r;
    assign vs           = vs_r;
    assign video_active = active_r;
    assign rdata        = rdata_r;
    assign gdata        = gdata_r;
    assign bdata        = bdata_r;
    assign x            = x_r;
    assign y            = y_r;
    assign frame_start  = frame_start_r;

endmodule

// File: tb/tb_vid_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vid_timing_gen
//
// Drives two small-geometry instances (active-high and active-low sync) and
// one default 720p instance from shared controls. A behavioural model derives
// the raster position from the number of enabled cycles since restart and
// computes expected outputs from the geometry and pattern rules directly.
// -----------------------------------------------------------------------------
module tb_vid_timing_gen;

    localparam int HT = 24;
    localparam int VT = 8;

    logic        sclk;
    logic        rst_n;
    logic        en;
    logic [1:0]  pat_sel;
    logic [23:0] solid_rgb;

    logic hs_p, vs_p, act_p, fs_p;
    logic [7:0] r_p, g_p, b_p;
    logic [4:0] x_p, y_p;
    logic hs_n, vs_n, act_n, fs_n;
    logic [7:0] r_n, g_n, b_n;
    logic [4:0] x_n, y_n;
    logic hs_h, vs_h, act_h, fs_h;
    logic [7:0] r_h, g_h, b_h;
    logic [10:0] x_h, y_h;

    int compared;
    int mismatched;

    // model state
    int          mt;
    logic [1:0]  sh_pat;
    logic [23:0] sh_solid;
    logic        e_hs, e_vs, e_act, e_fs, e_idle;
    logic [7:0]  e_r, e_g, e_b;
    int          e_x, e_y;

    vid_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(8)) dut_p (
        .sclk(sclk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs(hs_p), .vs(vs_p), .video_active(act_p), .rdata(r_p), .gdata(g_p), .bdata(b_p),
        .x(x_p), .y(y_p), .frame_start(fs_p));

    vid_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(8)) dut_n (
        .sclk(sclk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs(hs_n), .vs(vs_n), .video_active(act_n), .rdata(r_n), .gdata(g_n), .bdata(b_n),
        .x(x_n), .y(y_n), .frame_start(fs_n));

    vid_timing_gen dut_h (
        .sclk(sclk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs(hs_h), .vs(vs_h), .video_active(act_h), .rdata(r_h), .gdata(g_h), .bdata(b_h),
        .x(x_h), .y(y_h), .frame_start(fs_h));

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Expected pixel for raster position (h,v) straight from the pattern rules.
    function automatic logic [23:0] ref_pixel(input int h, input int v,
                                              input logic [1:0] p, input logic [23:0] s);
        int bar;
        logic [7:0] rv;
        case (p)
            2'd0: begin
                bar = h / 2;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: begin
                rv = 8'(h % 256);
                return {rv, rv, rv};
            end
            2'd2: return ((h % 16 == 0) || (v % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    // Advance the model by one clock using the current inputs, then step the clock.
    task automatic tick();
        int h, v;
        logic [23:0] px;
        if (en) begin
            h = mt % HT;
            v = (mt / HT) % VT;
            if (h == 0 && v == 0) begin
                sh_pat   = pat_sel;
                sh_solid = solid_rgb;
            end
            e_idle = 1'b0;
            e_act  = (h < 16) && (v < 4);
            e_hs   = (h >= 18) && (h < 21);
            e_vs   = (v >= 5) && (v < 7);
            e_fs   = (h == 0) && (v == 0);
            e_x    = h;
            e_y    = v;
            px     = e_act ? ref_pixel(h, v, sh_pat, sh_solid) : 24'h000000;
            mt++;
        end else begin
            e_idle = 1'b1;
            e_act  = 1'b0;
            e_hs   = 1'b0;
            e_vs   = 1'b0;
            e_fs   = 1'b0;
            e_x    = 0;
            e_y    = 0;
            px     = 24'h000000;
            mt     = 0;
        end
        {e_r, e_g, e_b} = px;
        @(posedge sclk);
        #1;
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        compared++;
        if ({hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p} !== {4'b0000, 24'h0, 5'd0, 5'd0}) begin
            mismatched++;
            $display("FAIL reset_idle_pos: got %h want 0", {hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p});
        end
        compared++;
        if ({hs_n, vs_n, act_n, fs_n} !== 4'b1100) begin
            mismatched++;
            $display("FAIL reset_idle_neg: got %b want 1100", {hs_n, vs_n, act_n, fs_n});
        end
        rst_n    = 1'b1;
        mt       = 0;
        sh_pat   = 2'd0;
        sh_solid = 24'h0;
        tick();
        compared++;
        if ({fs_p, act_p, x_p, y_p} !== {2'b11, 5'd0, 5'd0}) begin
            mismatched++;
            $display("FAIL first_frame_start: got fs=%b act=%b x=%0d y=%0d want 1 1 0 0", fs_p, act_p, x_p, y_p);
        end
    endtask

    task automatic test_frame_timing();
        int last_fs = -1, fs_cnt = 0, act_cnt = 0, line_cnt = 0;
        int act_rise = -1000, hs_rise = 0, vs_rise = 0;
        logic pa = 1'b0, ph = 1'b0, pv = 1'b0;
        pat_sel = 2'd0;
        restart();
        for (int c = 0; c < 384; c++) begin
            tick();
            if (fs_p) begin
                if (last_fs >= 0) begin
                    compared++;
                    if (c - last_fs != 192) begin
                        mismatched++;
                        $display("FAIL frame_period: got %0d want 192", c - last_fs);
                    end
                end
                last_fs = c;
                fs_cnt++;
            end
            if (act_p) act_cnt++;
            if (act_p && !pa) begin
                act_rise = c;
                line_cnt++;
            end
            if (hs_p && !ph) begin
                hs_rise = c;
                if (c - act_rise < 24) begin
                    compared++;
                    if (c - act_rise != 18) begin
                        mismatched++;
                        $display("FAIL hs_offset: got %0d want 18", c - act_rise);
                    end
                end
            end
            if (!hs_p && ph) begin
                compared++;
                if (c - hs_rise != 3) begin
                    mismatched++;
                    $display("FAIL hs_width: got %0d want 3", c - hs_rise);
                end
            end
            if (vs_p && !pv) begin
                vs_rise = c;
                compared++;
                if (c - last_fs != 120) begin
                    mismatched++;
                    $display("FAIL vs_offset: got %0d want 120", c - last_fs);
                end
            end
            if (!vs_p && pv) begin
                compared++;
                if (c - vs_rise != 48) begin
                    mismatched++;
                    $display("FAIL vs_width: got %0d want 48", c - vs_rise);
                end
            end
            compared++;
            if ({hs_n, vs_n} !== {~e_hs, ~e_vs}) begin
                mismatched++;
                $display("FAIL neg_polarity c=%0d: got %b%b want %b%b", c, hs_n, vs_n, ~e_hs, ~e_vs);
            end
            pa = act_p;
            ph = hs_p;
            pv = vs_p;
        end
        compared++;
        if (fs_cnt != 2) begin
            mismatched++;
            $display("FAIL frame_start_count: got %0d want 2", fs_cnt);
        end
        compared++;
        if (act_cnt != 128) begin
            mismatched++;
            $display("FAIL active_pixels: got %0d want 128", act_cnt);
        end
        compared++;
        if (line_cnt != 8) begin
            mismatched++;
            $display("FAIL active_lines: got %0d want 8", line_cnt);
        end
    endtask

    task automatic test_patterns();
        logic [23:0] want;
        logic        has_want;
        for (int p = 0; p < 4; p++) begin
            pat_sel   = 2'(p);
            solid_rgb = 24'h123456;
            restart();
            for (int c = 0; c < 192; c++) begin
                tick();
                compared++;
                if ({r_p, g_p, b_p} !== {e_r, e_g, e_b}) begin
                    mismatched++;
                    $display("FAIL pattern%0d_model x=%0d y=%0d: got %h want %h", p, e_x, e_y, {r_p, g_p, b_p}, {e_r, e_g, e_b});
                end
                has_want = 1'b0;
                want     = 24'h0;
                if (e_act) begin
                    case (p)
                        0: begin
                            if (e_x <= 1) begin has_want = 1'b1; want = 24'hFFFFFF; end
                            else if (e_x >= 14) begin has_want = 1'b1; want = 24'h000000; end
                            else if (e_x == 10) begin has_want = 1'b1; want = 24'hFF0000; end
                        end
                        1: begin has_want = 1'b1; want = {3{8'(e_x)}}; end
                        2: begin
                            if (e_x == 0 || e_y == 0) begin has_want = 1'b1; want = 24'hFFFFFF; end
                            else if (e_x == 5) begin has_want = 1'b1; want = 24'h000000; end
                        end
                        default: begin has_want = 1'b1; want = 24'h123456; end
                    endcase
                end
                if (has_want) begin
                    compared++;
                    if ({r_p, g_p, b_p} !== want) begin
                        mismatched++;
                        $display("FAIL pattern%0d_point x=%0d y=%0d: got %h want %h", p, e_x, e_y, {r_p, g_p, b_p}, want);
                    end
                end
            end
        end
        pat_sel = 2'd0;
    endtask

    task automatic test_midframe_switch();
        pat_sel   = 2'd0;
        solid_rgb = 24'hABCDEF;
        restart();
        for (int c = 0; c < 384; c++) begin
            tick();
            if (c == 48) pat_sel = 2'd3;
            if (c < 192 && e_act && (e_x == 0 || e_x == 10)) begin
                compared++;
                if ({r_p, g_p, b_p} !== ((e_x == 0) ? 24'hFFFFFF : 24'hFF0000)) begin
                    mismatched++;
                    $display("FAIL midframe_keep_bars x=%0d y=%0d: got %h", e_x, e_y, {r_p, g_p, b_p});
                end
            end
            if (c >= 192 && e_act) begin
                compared++;
                if ({r_p, g_p, b_p} !== 24'hABCDEF) begin
                    mismatched++;
                    $display("FAIL midframe_next_solid x=%0d y=%0d: got %h want abcdef", e_x, e_y, {r_p, g_p, b_p});
                end
            end
            if (c == 192) begin
                compared++;
                if (fs_p !== 1'b1) begin
                    mismatched++;
                    $display("FAIL midframe_frame_start: got %b want 1", fs_p);
                end
            end
        end
        pat_sel = 2'd0;
    endtask

    task automatic test_en_control();
        pat_sel = 2'd0;
        restart();
        for (int c = 0; c < 58; c++) tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p} !== {4'b0000, 24'h0, 5'd0, 5'd0}) begin
                mismatched++;
                $display("FAIL en_low_idle k=%0d: got %h want 0", k, {hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p});
            end
            compared++;
            if ({hs_n, vs_n, act_n} !== 3'b110) begin
                mismatched++;
                $display("FAIL en_low_idle_neg k=%0d: got %b want 110", k, {hs_n, vs_n, act_n});
            end
        end
        en = 1'b1;
        tick();
        compared++;
        if ({fs_p, act_p, x_p, y_p, r_p} !== {2'b11, 5'd0, 5'd0, 8'hFF}) begin
            mismatched++;
            $display("FAIL en_restart: got fs=%b act=%b x=%0d y=%0d r=%h want 1 1 0 0 ff", fs_p, act_p, x_p, y_p, r_p);
        end
    endtask

    task automatic test_reset_midline();
        pat_sel = 2'd0;
        restart();
        for (int c = 0; c < 30; c++) tick();
        compared++;
        if (act_p !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_active: got %b want 1", act_p);
        end
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p} !== {4'b0000, 24'h0, 5'd0, 5'd0}) begin
            mismatched++;
            $display("FAIL async_reset_idle: got %h want 0", {hs_p, vs_p, act_p, fs_p, r_p, g_p, b_p, x_p, y_p});
        end
        compared++;
        if ({hs_n, vs_n, act_n} !== 3'b110) begin
            mismatched++;
            $display("FAIL async_reset_idle_neg: got %b want 110", {hs_n, vs_n, act_n});
        end
        @(posedge sclk);
        #1;
        rst_n    = 1'b1;
        mt       = 0;
        sh_pat   = 2'd0;
        sh_solid = 24'h0;
        tick();
        compared++;
        if ({fs_p, x_p, y_p} !== {1'b1, 5'd0, 5'd0}) begin
            mismatched++;
            $display("FAIL post_reset_origin: got fs=%b x=%0d y=%0d want 1 0 0", fs_p, x_p, y_p);
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) pat_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) solid_rgb = 24'($urandom);
            if (en && $urandom_range(0, 399) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            tick();
            compared++;
            if ({hs_p, vs_p, act_p, fs_p} !== {e_hs, e_vs, e_act, e_fs}) begin
                mismatched++;
                $display("FAIL rand_ctrl c=%0d: got %b want %b", c, {hs_p, vs_p, act_p, fs_p}, {e_hs, e_vs, e_act, e_fs});
            end
            compared++;
            if ({r_p, g_p, b_p} !== {e_r, e_g, e_b}) begin
                mismatched++;
                $display("FAIL rand_pixel c=%0d: got %h want %h", c, {r_p, g_p, b_p}, {e_r, e_g, e_b});
            end
            compared++;
            if ({hs_n, vs_n, act_n, fs_n, r_n, g_n, b_n} !== {~e_hs, ~e_vs, e_act, e_fs, e_r, e_g, e_b}) begin
                mismatched++;
                $display("FAIL rand_neg c=%0d: got %h", c, {hs_n, vs_n, act_n, fs_n, r_n, g_n, b_n});
            end
            if (e_act || e_idle) begin
                compared++;
                if ({x_p, y_p, x_n, y_n} !== {5'(e_x), 5'(e_y), 5'(e_x), 5'(e_y)}) begin
                    mismatched++;
                    $display("FAIL rand_xy c=%0d: got %0d,%0d want %0d,%0d", c, x_p, y_p, e_x, e_y);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_720p();
        int last_rise = -1, rise_cnt = 0, run = 0, hs_rise = 0;
        logic pa = 1'b0, ph = 1'b0;
        pat_sel = 2'd0;
        restart();
        for (int c = 0; c < 1650 * 3; c++) begin
            tick();
            compared++;
            if (fs_h !== (c == 0)) begin
                mismatched++;
                $display("FAIL hd_frame_start c=%0d: got %b", c, fs_h);
            end
            if (act_h && !pa) begin
                if (last_rise >= 0) begin
                    compared++;
                    if (c - last_rise != 1650) begin
                        mismatched++;
                        $display("FAIL hd_line_period: got %0d want 1650", c - last_rise);
                    end
                end
                compared++;
                if ({y_h, r_h, g_h, b_h} !== {11'(rise_cnt), 24'hFFFFFF}) begin
                    mismatched++;
                    $display("FAIL hd_line_start: got y=%0d rgb=%h want y=%0d ffffff", y_h, {r_h, g_h, b_h}, rise_cnt);
                end
                last_rise = c;
                rise_cnt++;
                run = 0;
            end
            if (act_h) begin
                run++;
                if (run == 1280) begin
                    compared++;
                    if ({x_h, r_h, g_h, b_h} !== {11'd1279, 24'h000000}) begin
                        mismatched++;
                        $display("FAIL hd_last_pixel: got x=%0d rgb=%h want 1279 000000", x_h, {r_h, g_h, b_h});
                    end
                end
            end
            if (!act_h && pa) begin
                compared++;
                if (run != 1280) begin
                    mismatched++;
                    $display("FAIL hd_active_width: got %0d want 1280", run);
                end
            end
            if (hs_h && !ph) begin
                hs_rise = c;
                compared++;
                if (c - last_rise != 1390) begin
                    mismatched++;
                    $display("FAIL hd_hs_offset: got %0d want 1390", c - last_rise);
                end
            end
            if (!hs_h && ph) begin
                compared++;
                if (c - hs_rise != 40) begin
                    mismatched++;
                    $display("FAIL hd_hs_width: got %0d want 40", c - hs_rise);
                end
            end
            pa = act_h;
            ph = hs_h;
        end
        compared++;
        if ({rise_cnt, vs_h} !== {32'd3, 1'b0}) begin
            mismatched++;
            $display("FAIL hd_lines_vs: got lines=%0d vs=%b want 3 0", rise_cnt, vs_h);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        pat_sel    = 2'd0;
        solid_rgb  = 24'h0;
        mt         = 0;
        sh_pat     = 2'd0;
        sh_solid   = 24'h0;
        test_reset();
        test_frame_timing();
        test_patterns();
        test_midframe_switch();
        test_en_control();
        test_reset_midline();
        test_random();
        test_720p();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
